riscv_crypto_fu_saes32_masked_seq: RTL and testbench

RISCV_CRYPTO_FU_SAES32_MASKED_SEQ -- requirements
Module: riscv_crypto_fu_saes32_masked_seq

---
 rtl/riscv_crypto_fu_saes32_masked_seq_if.sv | 42 ++++
 rtl/riscv_crypto_fu_saes32_masked_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_riscv_crypto_fu_saes32_masked_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_crypto_fu_saes32_masked_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_crypto_fu_saes32_masked_seq_if
// Description : Request/response bundle for the masked sequential SAES32 unit.
//               master = issuing side, slave = functional unit.
//               Request : valid, flush, rs1, rs2, rs3, bs, op_*, rnd
//               Response: ready, busy, illegal, rd_shareA, rd_shareB
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_crypto_fu_saes32_masked_seq_if #(
    parameter int RAND_W = 8
);
    logic              valid;
    logic              flush;
    logic [31:0]       rs1;
    logic [31:0]       rs2;
    logic [31:0]       rs3;
    logic [1:0]        bs;
    logic              op_saes32_encs;
    logic              op_saes32_encsm;
    logic              op_saes32_decs;
    logic              op_saes32_decsm;
    logic [RAND_W-1:0] rnd;
    logic              ready;
    logic              busy;
    logic              illegal;
    logic [31:0]       rd_shareA;
    logic [31:0]       rd_shareB;

    modport master (
        output valid, flush, rs1, rs2, rs3, bs,
               op_saes32_encs, op_saes32_encsm, op_saes32_decs, op_saes32_decsm, rnd,
        input  ready, busy, illegal, rd_shareA, rd_shareB
    );

    modport slave (
        input  valid, flush, rs1, rs2, rs3, bs,
               op_saes32_encs, op_saes32_encsm, op_saes32_decs, op_saes32_decsm, rnd,
        output ready, busy, illegal, rd_shareA, rd_shareB
    );
endinterface
`default_nettype wire

// File: rtl/riscv_crypto_fu_saes32_masked_seq.sv
`default_nettype none
// ============================================================================
// Module      : riscv_crypto_fu_saes32_masked_seq
// Description : Two-share masked AES SAES32 functional unit. One state byte is
//               pushed through a DOM-masked (inverse) S-box with SBOX_STAGES
//               register stages, then MixColumn-expanded, rotated and re-masked.
// Ports       : clk, reset_n (async, active-low)
//               bus (slave) : valid/flush/rs1/rs2/rs3/bs/op_*/rnd in,
//                             ready/busy/illegal/rd_shareA/rd_shareB out
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_crypto_fu_saes32_masked_seq #(
    parameter int SAES_DEC_EN = 1,
    parameter int SBOX_STAGES = 2,
    parameter int RAND_W      = 8
) (
    input  wire logic clk,
    input  wire logic reset_n,
    riscv_crypto_fu_saes32_masked_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    localparam logic [7:0] C_AFF_FWD = 8'h63;
    localparam logic [7:0] C_AFF_INV = 8'h05;

    // ---------------- GF(2^8) helpers (polynomial 0x11B) ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // Linear parts of the forward/inverse affine maps; applied per share.
    function automatic logic [7:0] aff_lin(input logic [7:0] x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4);
    endfunction

    function automatic logic [7:0] inv_aff_lin(input logic [7:0] x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6);
    endfunction

    // DOM-indep multiplier: cross terms are blinded by z, so the shares are
    // never recombined; {c0,c1} XOR to (a0^a1)*(b0^b1).
    function automatic logic [15:0] dom_mul(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] z);
        logic [7:0] c0, c1;
        c0 = gf_mul(a0, b0) ^ (gf_mul(a0, b1) ^ z);
        c1 = gf_mul(a1, b1) ^ (gf_mul(a1, b0) ^ z);
        return {c0, c1};
    endfunction

    // Masked (inverse) S-box. Inversion is x^254 through the addition chain
    // x2, x3, x12, x15, x240, x252, x254; squarings are linear and run per share.
    function automatic logic [15:0] masked_sbox(input logic [7:0] in_a, input logic [7:0] in_b,
                                                input logic dec, input logic [7:0] r);
        logic [7:0] xa, xb, x2a, x2b, x3a, x3b, x12a, x12b, x15a, x15b;
        logic [7:0] x240a, x240b, x252a, x252b, x254a, x254b;
        logic [15:0] m;
        xa  = dec ? (inv_aff_lin(in_a) ^ C_AFF_INV) : in_a;
        xb  = dec ? inv_aff_lin(in_b) : in_b;
        x2a = gf_mul(xa, xa);
        x2b = gf_mul(xb, xb);
        m   = dom_mul(x2a, x2b, xa, xb, r);
        x3a = m[15:8];
        x3b = m[7:0];
        x12a = gf_mul(gf_mul(x3a, x3a), gf_mul(x3a, x3a));
        x12b = gf_mul(gf_mul(x3b, x3b), gf_mul(x3b, x3b));
        m    = dom_mul(x12a, x12b, x3a, x3b, rotl8(r, 1));
        x15a = m[15:8];
        x15b = m[7:0];
        x240a = x15a;
        x240b = x15b;
        for (int i = 0; i < 4; i++) begin
            x240a = gf_mul(x240a, x240a);
            x240b = gf_mul(x240b, x240b);
        end
        m     = dom_mul(x240a, x240b, x12a, x12b, rotl8(r, 2));
        x252a = m[15:8];
        x252b = m[7:0];
        m     = dom_mul(x252a, x252b, x2a, x2b, rotl8(r, 3));
        x254a = m[15:8];
        x254b = m[7:0];
        if (dec) return {x254a, x254b};
        return {aff_lin(x254a) ^ C_AFF_FWD, aff_lin(x254b)};
    endfunction

    function automatic logic [31:0] mix_col(input logic [7:0] s, input logic encm, input logic decm);
        if (encm) return {gf_mul(s, 8'h03), s, s, gf_mul(s, 8'h02)};
        if (decm) return {gf_mul(s, 8'h0b), gf_mul(s, 8'h0d), gf_mul(s, 8'h09), gf_mul(s, 8'h0e)};
        return {24'h000000, s};
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [1:0] b);
        case (b)
            2'd1:    return {x[23:0], x[31:24]};
            2'd2:    return {x[15:0], x[31:16]};
            2'd3:    return {x[7:0],  x[31:8]};
            default: return x;
        endcase
    endfunction

    // ---------------- state ----------------
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d, busy_q, busy_d, illegal_q, illegal_d;
    logic [7:0]        cap_a_q, cap_a_d, cap_b_q, cap_b_d;
    logic [31:0]       rs1_q, rs1_d;
    logic [1:0]        bs_q, bs_d;
    logic [3:0]        op_q, op_d;     // {decsm, decs, encsm, encs}
    logic [RAND_W-1:0] rnd_q, rnd_d;
    logic [7:0]        pipe_a_q [SBOX_STAGES];
    logic [7:0]        pipe_a_d [SBOX_STAGES];
    logic [7:0]        pipe_b_q [SBOX_STAGES];
    logic [7:0]        pipe_b_d [SBOX_STAGES];
    logic [31:0]       rd_a_q, rd_a_d, rd_b_q, rd_b_d;

    logic [3:0]  w_op;
    logic        w_legal;
    logic [31:0] w_refresh;
    logic [15:0] w_sbox;
    logic [31:0] w_res_a, w_res_b;

    // Fresh randomness replicated / truncated across the 32-bit word.
    for (genvar gi = 0; gi < 32; gi++) begin : g_refresh
        assign w_refresh[gi] = rnd_q[gi % RAND_W];
    end

    assign w_op    = {bus.op_saes32_decsm, bus.op_saes32_decs, bus.op_saes32_encsm, bus.op_saes32_encs};
    assign w_legal = (w_op != 4'd0) && ((w_op & (w_op - 4'd1)) == 4'd0) &&
                     ((SAES_DEC_EN != 0) || !(w_op[2] | w_op[3]));

    assign w_sbox  = masked_sbox(cap_a_q, cap_b_q, op_q[2] | op_q[3], w_refresh[7:0]);
    assign w_res_a = rotl32(mix_col(pipe_a_q[SBOX_STAGES-1], op_q[1], op_q[3]), bs_q) ^ rs1_q ^ w_refresh;
    assign w_res_b = rotl32(mix_col(pipe_b_q[SBOX_STAGES-1], op_q[1], op_q[3]), bs_q) ^ w_refresh;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = 1'b0;
        illegal_d = 1'b0;
        cap_a_d   = cap_a_q;
        cap_b_d   = cap_b_q;
        rs1_d     = rs1_q;
        bs_d      = bs_q;
        op_d      = op_q;
        rnd_d     = rnd_q;
        pipe_a_d  = pipe_a_q;
        pipe_b_d  = pipe_b_q;
        rd_a_d    = rd_a_q;
        rd_b_d    = rd_b_q;
        case (state_q)
            IDLE: begin
                if (bus.valid && !bus.flush) begin
                    if (w_legal) begin
                        cap_a_d = 8'(bus.rs2 >> {bus.bs, 3'b000});
                        cap_b_d = 8'(bus.rs3 >> {bus.bs, 3'b000});
                        rs1_d   = bus.rs1;
                        bs_d    = bus.bs;
                        op_d    = w_op;
                        rnd_d   = bus.rnd;
                        cnt_d   = 4'd0;
                        state_d = RUN;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            RUN: begin
                pipe_a_d[0] = w_sbox[15:8];
                pipe_b_d[0] = w_sbox[7:0];
                for (int i = 1; i < SBOX_STAGES; i++) begin
                    pipe_a_d[i] = pipe_a_q[i-1];
                    pipe_b_d[i] = pipe_b_q[i-1];
                end
                if (cnt_q == 4'(SBOX_STAGES - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                rd_a_d  = w_res_a;
                rd_b_d  = w_res_b;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort: results and ready are suppressed, outputs keep old values.
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            ready_d = 1'b0;
            rd_a_d  = rd_a_q;
            rd_b_d  = rd_b_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
            rs1_q     <= '0;
            bs_q      <= '0;
            op_q      <= '0;
            rnd_q     <= '0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            for (int i = 0; i < SBOX_STAGES; i++) begin
                pipe_a_q[i] <= '0;
                pipe_b_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
            cap_a_q   <= cap_a_d;
            cap_b_q   <= cap_b_d;
            rs1_q     <= rs1_d;
            bs_q      <= bs_d;
            op_q      <= op_d;
            rnd_q     <= rnd_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            pipe_a_q  <= pipe_a_d;
            pipe_b_q  <= pipe_b_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.illegal   = illegal_q;
    assign bus.rd_shareA = rd_a_q;
    assign bus.rd_shareB = rd_b_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_crypto_fu_saes32_masked_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_crypto_fu_saes32_masked_seq
// Description : Bench for the masked SAES32 unit. dut1 has decrypt enabled and
//               is tracked cycle by cycle against a transaction-level model;
//               dut0 has decrypt disabled and gets directed illegal-op checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_crypto_fu_saes32_masked_seq;
    localparam int S = 2;
    localparam logic [3:0] OP_ENCS = 4'b0001, OP_ENCSM = 4'b0010,
                           OP_DECS = 4'b0100, OP_DECSM = 4'b1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    riscv_crypto_fu_saes32_masked_seq_if #(.RAND_W(8)) bus1 ();
    riscv_crypto_fu_saes32_masked_seq_if #(.RAND_W(8)) bus0 ();

    riscv_crypto_fu_saes32_masked_seq #(.SAES_DEC_EN(1), .SBOX_STAGES(S), .RAND_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    riscv_crypto_fu_saes32_masked_seq #(.SAES_DEC_EN(0), .SBOX_STAGES(S), .RAND_W(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_sb  [256];
    logic [7:0] m_isb [256];

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (m_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            m_sb[x]  = s;
            m_isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] f_exp(input logic [3:0] op, input logic [31:0] a1,
                                          input logic [31:0] a2, input logic [31:0] a3,
                                          input logic [1:0] b);
        logic [7:0] x, s;
        logic [31:0] col;
        int sh;
        sh = 8 * int'(b);
        x  = 8'((a2 ^ a3) >> sh);
        s  = (op[2] | op[3]) ? m_isb[x] : m_sb[x];
        if (op[1])      col = {m_gmul(s, 8'd3), s, s, m_gmul(s, 8'd2)};
        else if (op[3]) col = {m_gmul(s, 8'd11), m_gmul(s, 8'd13), m_gmul(s, 8'd9), m_gmul(s, 8'd14)};
        else            col = {24'h0, s};
        if (sh != 0) col = (col << sh) | (col >> (32 - sh));
        return col ^ a1;
    endfunction

    int          cyc = 0;
    int          m_due = 0;
    logic        m_pend = 0, m_ready = 0, m_ill = 0;
    logic [31:0] m_rd = 0, m_val = 0;
    logic [3:0]  w_op1;
    logic [31:0] rd1;
    assign w_op1 = {bus1.op_saes32_decsm, bus1.op_saes32_decs, bus1.op_saes32_encsm, bus1.op_saes32_encs};
    assign rd1   = bus1.rd_shareA ^ bus1.rd_shareB;

    // One transaction in flight; completes S+1 edges after acceptance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = 0; m_ready = 0; m_ill = 0; m_rd = 0;
        end else begin
            cyc++;
            m_ready = 0;
            m_ill   = 0;
            if (bus1.flush) m_pend = 0;
            else if (m_pend) begin
                if (cyc == m_due) begin m_pend = 0; m_ready = 1; m_rd = m_val; end
            end else if (bus1.valid) begin
                if ($countones(w_op1) != 1) m_ill = 1;
                else begin
                    m_pend = 1;
                    m_due  = cyc + S + 1;
                    m_val  = f_exp(w_op1, bus1.rs1, bus1.rs2, bus1.rs3, bus1.bs);
                end
            end
        end
    end

    int ready_cnt = 0;
    always @(negedge clk) begin
        chk("ready",   32'(bus1.ready),   32'(m_ready));
        chk("busy",    32'(bus1.busy),    32'(m_pend));
        chk("illegal", 32'(bus1.illegal), 32'(m_ill));
        chk("rd",      rd1,               m_rd);
        if (bus1.ready) ready_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [1:0] b, input logic [7:0] r,
                         input int hold, output int acc);
        {bus1.op_saes32_decsm, bus1.op_saes32_decs, bus1.op_saes32_encsm, bus1.op_saes32_encs} = op;
        bus1.rs1 = a1; bus1.rs2 = a2; bus1.rs3 = a3; bus1.bs = b; bus1.rnd = r;
        bus1.valid = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        for (int k = 1; k < hold; k++) begin @(posedge clk); #1; end
        bus1.valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3, input logic [1:0] b,
                          input logic [7:0] r, input logic [31:0] exp);
        int acc;
        bit got;
        got = 0;
        issue(op, a1, a2, a3, b, r, 1, acc);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus1.ready) got = 1;
        end
        chk({nm, "_lat"}, got ? 32'(cyc - acc) : 32'hffffffff, 32'(S + 1));
        chk(nm, rd1, exp);
    endtask

    initial begin
        int acc, base, rc;
        logic [31:0] r;
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, base, rc;
        logic [31:0] r;
        bus1.valid = 0; bus1.flush = 0; bus1.rs1 = 0; bus1.rs2 = 0; bus1.rs3 = 0; bus1.bs = 0;
        bus1.rnd = 0; {bus1.op_saes32_decsm, bus1.op_saes32_decs, bus1.op_saes32_encsm, bus1.op_saes32_encs} = 0;
        bus0.valid = 0; bus0.flush = 0; bus0.rs1 = 0; bus0.rs2 = 0; bus0.rs3 = 0; bus0.bs = 0;
        bus0.rnd = 0; {bus0.op_saes32_decsm, bus0.op_saes32_decs, bus0.op_saes32_encsm, bus0.op_saes32_encs} = 0;
        build_tables();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus1.ready), 0);
        chk("rst_busy",  32'(bus1.busy),  0);
        chk("rst_rdA",   bus1.rd_shareA,  0);
        chk("rst_rdB",   bus1.rd_shareB,  0);
        @(posedge clk); #1;

        run_op("encsm_zero", OP_ENCSM, 32'h0, 32'h0, 32'h0, 2'd0, 8'h5a, 32'ha56363c6);
        run_op("encs_53",    OP_ENCS, 32'h01000000, 32'h00000053, 32'h0, 2'd0, 8'h3c, 32'h010000ed);
        r = $urandom;
        run_op("encs_remask", OP_ENCS, 32'h01000000, 32'h00000053 ^ r, r, 2'd0, 8'hc7, 32'h010000ed);
        run_op("decs_63",    OP_DECS, 32'h0, 32'h63000000, 32'h0, 2'd3, 8'h11, 32'h00000000);
        run_op("encs_63_rot", OP_ENCS, 32'h0, 32'h63000000, 32'h0, 2'd3, 8'h99, 32'hfb000000);
        run_op("decsm_7c",   OP_DECSM, 32'h0, 32'h0000007c, 32'h0, 2'd0, 8'ha1, 32'h0b0d090e);
        run_op("encsm_bs1",  OP_ENCSM, 32'hffffffff, 32'h11220033, 32'h55660077, 2'd1, 8'he4, 32'h9c9c395a);

        // Flush one cycle after accept, then an immediate fresh request.
        issue(OP_ENCSM, 32'h0, 32'h0, 32'h0, 2'd0, 8'h77, 1, acc);
        bus1.flush = 1'b1;
        @(posedge clk); #1 bus1.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(bus1.busy), 0);
        @(posedge clk); #1;
        run_op("after_flush", OP_ENCS, 32'h01000000, 32'h00000053, 32'h0, 2'd0, 8'h42, 32'h010000ed);

        // Non-one-hot ops are rejected.
        issue(4'b0000, 32'h0, 32'h0, 32'h0, 2'd0, 8'h0, 1, acc);
        @(negedge clk);
        chk("ill_zero", 32'(bus1.illegal), 1);
        @(posedge clk); #1;
        issue(4'b0011, 32'h0, 32'h0, 32'h0, 2'd0, 8'h0, 1, acc);
        @(negedge clk);
        chk("ill_multi", 32'(bus1.illegal), 1);
        chk("ill_multi_busy", 32'(bus1.busy), 0);
        @(posedge clk); #1;

        // Valid held across the whole operation yields one result only.
        base = ready_cnt;
        issue(OP_ENCS, 32'h0, 32'h00000053, 32'h0, 2'd0, 8'h00, S + 2, acc);
        repeat (S + 5) @(negedge clk);
        chk("held_single_ready", 32'(ready_cnt - base), 1);
        @(posedge clk); #1;

        // Reset during RUN: outputs clear and the op never completes.
        issue(OP_ENCSM, 32'h0, 32'h0, 32'h0, 2'd0, 8'h5a, 1, acc);
        @(negedge clk); #2 reset_n = 1'b0;
        @(negedge clk);
        chk("rstrun_rdA", bus1.rd_shareA, 0);
        chk("rstrun_rdB", bus1.rd_shareB, 0);
        chk("rstrun_busy", 32'(bus1.busy), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        base = ready_cnt;
        repeat (S + 4) @(negedge clk);
        chk("rstrun_no_ready", 32'(ready_cnt - base), 0);

        // Decrypt-disabled instance rejects decsm.
        @(posedge clk); #1;
        bus0.op_saes32_decsm = 1'b1; bus0.rs2 = 32'h7c; bus0.valid = 1'b1;
        @(posedge clk); #1 bus0.valid = 1'b0;
        @(negedge clk);
        chk("dis_illegal", 32'(bus0.illegal), 1);
        chk("dis_busy", 32'(bus0.busy), 0);
        rc = 0;
        for (int k = 0; k < S + 4; k++) begin
            @(negedge clk);
            if (bus0.ready) rc++;
        end
        chk("dis_no_ready", 32'(rc), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
